// File: rtl/vu_pkg.sv
// Shared definitions for the vector unit: opcode encodings and FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vu_pkg;

   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_STORE   = 2'b01;
   localparam logic [1:0] OP_SUM     = 2'b10;
   localparam logic [1:0] OP_PRODUCT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/vu_lane_mul.sv
// One lane multiplier: full-width LANE_W x LANE_W product, purely combinational.
// Latency: 0 cycles (the caller registers the result).
// Backpressure: none. Ports: a, b (lane operands) -> p (2*LANE_W product).
// Define VU_SIGNED_EN for two's-complement operands; unsigned otherwise.
module vu_lane_mul #(
   parameter int LANE_W = 32
) (
   input  logic [LANE_W-1:0]   a,
   input  logic [LANE_W-1:0]   b,
   output logic [2*LANE_W-1:0] p
);

`ifdef VU_SIGNED_EN
   // Extend to full product width first so the low 2*LANE_W bits are exact.
   logic signed [2*LANE_W-1:0] a_x;
   logic signed [2*LANE_W-1:0] b_x;
   assign a_x = {{LANE_W{a[LANE_W-1]}}, a};
   assign b_x = {{LANE_W{b[LANE_W-1]}}, b};
   assign p   = a_x * b_x;
`else
   assign p = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
`endif

endmodule

// File: rtl/vector_unit.sv
// Vector unit: four vector registers A1..A4, a word memory, LOAD/STORE/SUM/PRODUCT commands.
// Latency: LOAD/STORE/SUM done 2 edges after accept; PRODUCT done LANES+1 edges after accept.
// Backpressure: start and host_we are ignored while busy; nothing is queued.
// Ports: clk, reset (async, high); start/operation/reg_sel/add command; host_we/data_in host write;
//        data_out (last loaded/stored vector), busy, done (one-cycle pulse).
// Define VU_SIGNED_EN for two's-complement lane arithmetic (default unsigned).
module vector_unit
   import vu_pkg::*;
#(
   parameter int  LANES  = 16,
   parameter int  LANE_W = 32,
   parameter int  ADDR_W = 9,
   localparam int DATA_W = LANES * LANE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        operation,
   input  logic [1:0]        reg_sel,
   input  logic [ADDR_W-1:0] add,
   input  logic              host_we,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done
);

   localparam int              CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   state_t              state, state_nxt;
   logic [1:0]          op_q, sel_q;
   logic [ADDR_W-1:0]   add_q;
   logic                exec_ph;      // EXEC phase: 0 = memory read, 1 = execute
   logic                mul_issued;   // all lanes sent into the product register
   logic                wb_vld;       // prod_q holds a lane result to write back
   logic [CNT_W-1:0]    lane_cnt, wb_idx;
   logic [LANE_W-1:0]   mul_a, mul_b;
   logic [2*LANE_W-1:0] lane_prod, prod_q;
   logic [DATA_W-1:0]   sum_lo, sum_hi, rd_q;
   logic [DATA_W-1:0]   a_reg [4];
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   // ---------------- lane arithmetic ----------------
   for (genvar i = 0; i < LANES; i++) begin : g_sum
      logic [LANE_W-1:0] x, y;
      logic [LANE_W:0]   s;
      assign x = a_reg[0][i*LANE_W +: LANE_W];
      assign y = a_reg[1][i*LANE_W +: LANE_W];
`ifdef VU_SIGNED_EN
      assign s = {x[LANE_W-1], x} + {y[LANE_W-1], y};
      assign sum_hi[i*LANE_W +: LANE_W] = {LANE_W{s[LANE_W]}};
`else
      assign s = {1'b0, x} + {1'b0, y};
      assign sum_hi[i*LANE_W +: LANE_W] = {{(LANE_W-1){1'b0}}, s[LANE_W]};
`endif
      assign sum_lo[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
   end

   assign mul_a = a_reg[0][int'(lane_cnt)*LANE_W +: LANE_W];
   assign mul_b = a_reg[1][int'(lane_cnt)*LANE_W +: LANE_W];

   vu_lane_mul #(.LANE_W(LANE_W)) u_lane_mul (
      .a (mul_a),
      .b (mul_b),
      .p (lane_prod)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (operation == OP_PRODUCT) ? ST_MUL : ST_EXEC;
         end
         ST_EXEC: if (exec_ph)    state_nxt = ST_DONE;
         ST_MUL:  if (mul_issued) state_nxt = ST_DONE;
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= OP_LOAD;
         sel_q      <= '0;
         add_q      <= '0;
         exec_ph    <= 1'b0;
         mul_issued <= 1'b0;
         wb_vld     <= 1'b0;
         lane_cnt   <= '0;
         wb_idx     <= '0;
         prod_q     <= '0;
         data_out   <= '0;
         for (int r = 0; r < 4; r++) a_reg[r] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               exec_ph    <= 1'b0;
               mul_issued <= 1'b0;
               wb_vld     <= 1'b0;
               if (start) begin
                  op_q  <= operation;
                  sel_q <= reg_sel;
                  add_q <= add;
               end
            end
            ST_EXEC: begin
               exec_ph <= 1'b1;
               if (exec_ph) begin
                  case (op_q)
                     OP_LOAD: begin
                        a_reg[sel_q] <= rd_q;
                        data_out     <= rd_q;
                     end
                     OP_STORE: data_out <= a_reg[sel_q];
                     OP_SUM: begin
                        a_reg[2] <= sum_lo;
                        a_reg[3] <= sum_hi;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               // Product is registered; each lane is written back one cycle after issue,
               // so the final cycle in MUL only drains the last lane.
               wb_vld <= !mul_issued;
               if (!mul_issued) begin
                  prod_q <= lane_prod;
                  wb_idx <= lane_cnt;
                  if (lane_cnt == LAST_LANE) begin
                     lane_cnt   <= '0;
                     mul_issued <= 1'b1;
                  end else begin
                     lane_cnt <= lane_cnt + 1'b1;
                  end
               end
               if (wb_vld) begin
                  a_reg[2][int'(wb_idx)*LANE_W +: LANE_W] <= prod_q[LANE_W-1:0];
                  a_reg[3][int'(wb_idx)*LANE_W +: LANE_W] <= prod_q[2*LANE_W-1:LANE_W];
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- vector memory (not reset) ----------------
   // Synchronous read every cycle; EXEC phase 0 captures the post-host-write word.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && host_we)
         mem[add] <= data_in;
      if (state == ST_EXEC && exec_ph && op_q == OP_STORE)
         mem[add_q] <= a_reg[sel_q];
      rd_q <= mem[add_q];
   end

endmodule

// File: tb/tb_vector_unit.sv
// Bench for vector_unit: directed commands push expected (done cycle, data_out) into a scoreboard;
// a negedge monitor pops and compares on every done pulse.
// Latency/backpressure: checks 2-edge and LANES+1-edge completion, ignored start/host_we while busy.
module tb_vector_unit;
   import vu_pkg::*;

   localparam int DW    = 512;
   localparam int LAT_X = 2;
   localparam int LAT_P = 17;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    operation;
   logic [1:0]    reg_sel;
   logic [8:0]    add;
   logic          host_we;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          busy;
   logic          done;

   typedef struct {
      int            id;
      int            cyc;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   n_cmd = 0;

   logic [DW-1:0] v_pat, all_f, ones, twos, var_b, var_lo, var_hi, ffe;

   vector_unit #(.LANES(16), .LANE_W(32), .ADDR_W(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .operation (operation),
      .reg_sel   (reg_sel),
      .add       (add),
      .host_we   (host_we),
      .data_in   (data_in),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding command.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done cyc=%0d", cyc);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("done_cyc#%0d", mon_e.id), DW'(cyc), DW'(mon_e.cyc));
            check($sformatf("data_out#%0d", mon_e.id), data_out, mon_e.dat);
         end
      end
   end

   task automatic host_write(input logic [8:0] ad, input logic [DW-1:0] wd);
      host_we = 1'b1;
      add     = ad;
      data_in = wd;
      @(negedge clk);
      host_we = 1'b0;
      data_in = '0;
   endtask

   // Issue one command at a negedge; optionally write memory on the same edge,
   // and optionally poke start/host_we while the command is running.
   task automatic cmd(input logic [1:0] op, input logic [1:0] sel, input logic [8:0] ad,
                      input logic [DW-1:0] exp_d, input int lat,
                      input bit we, input logic [DW-1:0] wd, input bit poke);
      exp_t e;
      bit   ok;
      e.id  = n_cmd;
      e.cyc = cyc + 1 + lat;
      e.dat = exp_d;
      sb.push_back(e);
      n_cmd++;
      start     = 1'b1;
      operation = op;
      reg_sel   = sel;
      add       = ad;
      host_we   = we;
      data_in   = wd;
      @(negedge clk);
      // Scramble inputs after acceptance: the latched command must not follow them.
      start     = 1'b0;
      host_we   = 1'b0;
      operation = ~op;
      reg_sel   = ~sel;
      add       = ~ad;
      ok        = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (poke && i == 3) begin
            start     = 1'b1;
            operation = OP_LOAD;
            add       = 9'd511;
            host_we   = 1'b1;
            data_in   = ~v_pat;
         end
         if (poke && i == 4) begin
            start   = 1'b0;
            host_we = 1'b0;
         end
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL cmd_timeout id=%0d busy=%0b", e.id, busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      v_pat = {4{128'h1122_3344_5566_7788_9900_AABB_CCDD_EEFF}};
      all_f = '1;
      ones  = {16{32'h0000_0001}};
      twos  = {16{32'h0000_0002}};
      ffe   = {16{32'hFFFF_FFFE}};
      for (int i = 0; i < 16; i++) begin
         var_b [i*32 +: 32] = 32'(i + 2);
         var_lo[i*32 +: 32] = 32'hFFFF_FFFF - 32'(i + 1);
         var_hi[i*32 +: 32] = 32'(i + 1);
      end

      reset = 1'b1; start = 1'b0; operation = 2'b00; reg_sel = 2'b00;
      add = '0; host_we = 1'b0; data_in = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_busy", DW'(busy), '0);
      check("rst_done", DW'(done), '0);
      check("rst_data_out", data_out, '0);
      @(negedge clk);

      // Registers come out of reset as zero.
      for (int r = 0; r < 4; r++) cmd(OP_STORE, 2'(r), 9'(r), '0, LAT_X, 1'b0, '0, 1'b0);

      // Top address, LOAD/STORE round trip.
      host_write(9'd511, v_pat);
      cmd(OP_LOAD,  2'd1, 9'd511, v_pat, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_STORE, 2'd1, 9'd0,   v_pat, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_LOAD,  2'd0, 9'd0,   v_pat, LAT_X, 1'b0, '0, 1'b0);

      // SUM: A1 = all ones, A2 lanes = 1 (A2 loaded with host write on the accepting edge).
      host_write(9'd10, all_f);
      cmd(OP_LOAD, 2'd0, 9'd10,  all_f, LAT_X, 1'b0, '0,   1'b0);
      cmd(OP_LOAD, 2'd1, 9'd11,  ones,  LAT_X, 1'b1, ones, 1'b0);
      cmd(OP_LOAD, 2'd2, 9'd511, v_pat, LAT_X, 1'b0, '0,   1'b0);
      cmd(OP_SUM,  2'd0, 9'd0,   v_pat, LAT_X, 1'b0, '0,   1'b0);
      cmd(OP_STORE, 2'd2, 9'd20, '0,    LAT_X, 1'b0, '0,   1'b0);
      cmd(OP_STORE, 2'd3, 9'd21, ones,  LAT_X, 1'b0, '0,   1'b0);

      // PRODUCT: A2 lanes = 2, with start/host_we poked mid-command.
      host_write(9'd12, twos);
      cmd(OP_LOAD, 2'd3, 9'd12, twos, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_LOAD, 2'd1, 9'd12, twos, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_PRODUCT, 2'd0, 9'd0, twos, LAT_P, 1'b0, '0, 1'b1);
      cmd(OP_STORE, 2'd2, 9'd22, ffe,  LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_STORE, 2'd3, 9'd23, ones, LAT_X, 1'b0, '0, 1'b0);

      // PRODUCT with distinct lane operands: lane i = FFFF_FFFF * (i+2).
      host_write(9'd13, var_b);
      cmd(OP_LOAD, 2'd1, 9'd13, var_b, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_PRODUCT, 2'd0, 9'd0, var_b, LAT_P, 1'b0, '0, 1'b0);
      cmd(OP_STORE, 2'd2, 9'd24, var_lo, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_STORE, 2'd3, 9'd25, var_hi, LAT_X, 1'b0, '0, 1'b0);

      // Reset in the middle of a PRODUCT (lane 5); no done is expected for it.
      start = 1'b1; operation = OP_PRODUCT; reg_sel = 2'd0; add = 9'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_busy", DW'(busy), '0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_done", DW'(done), '0);
      check("midrst_data_out", data_out, '0);
      @(negedge clk);
      for (int r = 0; r < 4; r++) cmd(OP_STORE, 2'(r), 9'(r), '0, LAT_X, 1'b0, '0, 1'b0);
      cmd(OP_LOAD, 2'd0, 9'd511, v_pat, LAT_X, 1'b0, '0, 1'b0);

      repeat (5) @(negedge clk);
      check("sb_empty", DW'(sb.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
